// File: rtl/multi_stream_splitter.sv
// Splits a headered input word stream into per-channel sample packets and message packets.
// Every output is registered one cycle after the accepted input word.
module multi_stream_splitter #(
   parameter int WDTH     = 32,
   parameter int N_CH     = 4,
   parameter int CH_BITS  = 2,
   parameter int LEN_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WDTH-1:0]     in_data,
   input  logic                in_nd,
   output logic [WDTH-1:0]     out_samples,
   output logic [N_CH-1:0]     out_samples_nd,
   output logic                out_samples_last,
   output logic [WDTH-1:0]     out_msg,
   output logic                out_msg_nd,
   output logic                out_msg_last,
   output logic                error
);

   // state   | meaning
   // IDLE    | next valid word is parsed as a header
   // SAMPLES | forwarding payload to the latched sample channel
   // MSG     | forwarding message payload
   // DROP    | discarding payload of a sample packet with a bad channel id
   typedef enum logic [1:0] {IDLE, SAMPLES, MSG, DROP} state_t;

   localparam logic [CH_BITS:0] NCH_W = (CH_BITS+1)'(N_CH);

   state_t              state, state_n;
   logic [LEN_BITS-1:0] cnt, cnt_n;
   logic [CH_BITS-1:0]  ch, ch_n;

   logic [WDTH-1:0]     samples_n, msg_n;
   logic [N_CH-1:0]     samples_nd_n;
   logic                samples_last_n, msg_nd_n, msg_last_n, error_n;

   logic                hdr_mark, hdr_is_msg, hdr_ch_ok;
   logic [CH_BITS-1:0]  hdr_ch;
   logic [LEN_BITS-1:0] hdr_len;

   assign hdr_mark   = in_data[WDTH-1];
   assign hdr_is_msg = in_data[WDTH-2];
   assign hdr_ch     = in_data[WDTH-3 -: CH_BITS];
   assign hdr_len    = in_data[LEN_BITS-1:0];
   assign hdr_ch_ok  = ({1'b0, hdr_ch} < NCH_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ch    <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ch    <= ch_n;
      end
   end

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      ch_n           = ch;
      samples_n      = '0;
      samples_nd_n   = '0;
      samples_last_n = 1'b0;
      msg_n          = '0;
      msg_nd_n       = 1'b0;
      msg_last_n     = 1'b0;
      error_n        = 1'b0;
      if (in_nd) begin
         case (state)
            IDLE: begin
               if (!hdr_mark) begin
                  error_n = 1'b1;
               end else if (hdr_is_msg) begin
                  msg_n    = in_data;
                  msg_nd_n = 1'b1;
                  if (hdr_len == '0) begin
                     msg_last_n = 1'b1;
                  end else begin
                     cnt_n   = hdr_len;
                     state_n = MSG;
                  end
               end else if (!hdr_ch_ok) begin
                  error_n = 1'b1;
                  if (hdr_len != '0) begin
                     cnt_n   = hdr_len;
                     state_n = DROP;
                  end
               end else if (hdr_len != '0) begin
                  ch_n    = hdr_ch;
                  cnt_n   = hdr_len;
                  state_n = SAMPLES;
               end
            end
            SAMPLES: begin
               samples_n    = in_data;
               samples_nd_n = N_CH'(1) << ch;
               cnt_n        = cnt - LEN_BITS'(1);
               if (cnt == LEN_BITS'(1)) begin
                  samples_last_n = 1'b1;
                  state_n        = IDLE;
               end
            end
            MSG: begin
               msg_n    = in_data;
               msg_nd_n = 1'b1;
               cnt_n    = cnt - LEN_BITS'(1);
               if (cnt == LEN_BITS'(1)) begin
                  msg_last_n = 1'b1;
                  state_n    = IDLE;
               end
            end
            DROP: begin
               cnt_n = cnt - LEN_BITS'(1);
               if (cnt == LEN_BITS'(1)) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Data outputs are zeroed when not valid so idle cycles are easy to read on a scope.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_samples      <= '0;
         out_samples_nd   <= '0;
         out_samples_last <= 1'b0;
         out_msg          <= '0;
         out_msg_nd       <= 1'b0;
         out_msg_last     <= 1'b0;
         error            <= 1'b0;
      end else begin
         out_samples      <= samples_n;
         out_samples_nd   <= samples_nd_n;
         out_samples_last <= samples_last_n;
         out_msg          <= msg_n;
         out_msg_nd       <= msg_nd_n;
         out_msg_last     <= msg_last_n;
         error            <= error_n;
      end
   end

endmodule
